// File: rtl/spi_pwm_pkg.sv
// Shared constants and types for the SPI-controlled PWM bank.
package spi_pwm_pkg;

    localparam int unsigned ADDR_W       = 4;
    localparam logic [ADDR_W-1:0] CTRL_ADDR = 4'hF;
    localparam int unsigned CMD_W_BIT    = 7;
    localparam int unsigned CTRL_EN_BIT  = 0;
    localparam int unsigned CTRL_INV_BIT = 1;

    typedef enum logic [1:0] {
        SPI_IDLE = 2'd0,
        SPI_CMD  = 2'd1,
        SPI_DATA = 2'd2,
        SPI_DONE = 2'd3
    } spi_state_e;

endpackage

// File: rtl/spi_byte_engine.sv
// SPI mode-0 slave front end: pin synchronisers, sclk edge detect, command/data
// shifting and read serialisation. Register storage lives in the parent.
module spi_byte_engine
    import spi_pwm_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    output logic [ADDR_W-1:0] addr,
    output logic              wr_strobe_c,
    output logic [WIDTH-1:0]  wr_data_c,
    output logic              rd_req_c,
    input  logic [WIDTH-1:0]  rd_data
);

    localparam int unsigned DW    = 8 * ((WIDTH + 7) / 8);
    localparam int unsigned CNT_W = $clog2(DW);

    logic [1:0]       sclk_q, cs_q, mosi_q;
    logic             sclk_d;
    logic             sclk_s, cs_s, mosi_s, rise, fall;
    spi_state_e       state, state_nx;
    logic [CNT_W-1:0] bit_cnt;
    logic [6:0]       cmd_sr;
    logic [7:0]       cmd_byte;
    logic             cmd_w;
    logic [WIDTH-2:0] in_sr;
    logic [DW-1:0]    out_sr;
    logic [DW-1:0]    rd_ext;
    logic             rd_loaded;
    logic             last_cmd, last_data;

    assign sclk_s    = sclk_q[1];
    assign cs_s      = cs_q[1];
    assign mosi_s    = mosi_q[1];
    assign rise      = sclk_s & ~sclk_d;
    assign fall      = ~sclk_s & sclk_d;
    assign cmd_byte  = {cmd_sr, mosi_s};
    assign rd_ext    = DW'(rd_data);
    assign last_cmd  = (bit_cnt == CNT_W'(7));
    assign last_data = (bit_cnt == CNT_W'(DW - 1));

    // Two-flop synchronisers plus delayed sclk for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_q <= 2'b00;
            cs_q   <= 2'b11;
            mosi_q <= 2'b00;
            sclk_d <= 1'b0;
        end else begin
            sclk_q <= {sclk_q[0], sclk};
            cs_q   <= {cs_q[0], cs_n};
            mosi_q <= {mosi_q[0], mosi};
            sclk_d <= sclk_s;
        end
    end

    // Frame state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= SPI_IDLE;
        else          state <= state_nx;
    end

    // Next-state and strobe decode
    always_comb begin
        state_nx    = state;
        wr_strobe_c = 1'b0;
        wr_data_c   = {in_sr, mosi_s};
        rd_req_c    = 1'b0;
        case (state)
            SPI_IDLE: if (!cs_s) state_nx = SPI_CMD;
            SPI_CMD:  if (rise && last_cmd) state_nx = SPI_DATA;
            SPI_DATA: begin
                if (rise && last_data) begin
                    state_nx    = SPI_DONE;
                    wr_strobe_c = cmd_w;
                end
                rd_req_c = fall && !rd_loaded && !cmd_w;
            end
            default: state_nx = state;
        endcase
        if (cs_s) begin
            state_nx    = SPI_IDLE;
            wr_strobe_c = 1'b0;
            rd_req_c    = 1'b0;
        end
    end

    // Bit counting, shift registers and miso driver
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt   <= '0;
            cmd_sr    <= '0;
            cmd_w     <= 1'b0;
            addr      <= '0;
            in_sr     <= '0;
            out_sr    <= '0;
            rd_loaded <= 1'b0;
            miso      <= 1'b0;
        end else if (cs_s) begin
            bit_cnt   <= '0;
            cmd_sr    <= '0;
            cmd_w     <= 1'b0;
            addr      <= '0;
            in_sr     <= '0;
            out_sr    <= '0;
            rd_loaded <= 1'b0;
            miso      <= 1'b0;
        end else begin
            case (state)
                SPI_CMD: if (rise) begin
                    cmd_sr <= cmd_byte[6:0];
                    if (last_cmd) begin
                        bit_cnt <= '0;
                        cmd_w   <= cmd_byte[CMD_W_BIT];
                        addr    <= cmd_byte[ADDR_W-1:0];
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                SPI_DATA: begin
                    if (rise) begin
                        in_sr   <= wr_data_c[WIDTH-2:0];
                        bit_cnt <= last_data ? '0 : bit_cnt + CNT_W'(1);
                    end
                    if (fall && !cmd_w) begin
                        if (!rd_loaded) begin
                            miso      <= rd_ext[DW-1];
                            out_sr    <= {rd_ext[DW-2:0], 1'b0};
                            rd_loaded <= 1'b1;
                        end else begin
                            miso   <= out_sr[DW-1];
                            out_sr <= {out_sr[DW-2:0], 1'b0};
                        end
                    end
                end
                SPI_DONE: if (fall) miso <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/spi_pwm_bank.sv
// SPI-configured PWM bank: shared period counter, per-channel level compare,
// global enable/invert control. Define SPI_PWM_SHADOW_EN for period-aligned
// (glitch-free) level updates through shadow registers.
module spi_pwm_bank
    import spi_pwm_pkg::*;
#(
    parameter int unsigned CHANNELS = 7,
    parameter int unsigned WIDTH    = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                sclk,
    input  logic                cs_n,
    input  logic                mosi,
    output logic                miso,
    output logic [CHANNELS-1:0] pwm_out
);

    localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'((32'd1 << WIDTH) - 32'd2);

    logic [ADDR_W-1:0] addr;
    logic              wr_strobe_c;
    logic [WIDTH-1:0]  wr_data_c;
    logic              rd_req_c;
    logic [WIDTH-1:0]  rd_data;
    logic [WIDTH-1:0]  counter;
    logic              wrap;
    logic              en, inv;
    logic [WIDTH-1:0]  level  [CHANNELS];
    logic [WIDTH-1:0]  rd_src [CHANNELS];

    spi_byte_engine #(.WIDTH(WIDTH)) u_engine (
        .clk         (clk),
        .reset_n     (reset_n),
        .sclk        (sclk),
        .cs_n        (cs_n),
        .mosi        (mosi),
        .miso        (miso),
        .addr        (addr),
        .wr_strobe_c (wr_strobe_c),
        .wr_data_c   (wr_data_c),
        .rd_req_c    (rd_req_c),
        .rd_data     (rd_data)
    );

    assign wrap = (counter == CNT_MAX);

    // Free-running period counter, 0 .. 2^WIDTH-2
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) counter <= '0;
        else          counter <= wrap ? '0 : counter + WIDTH'(1);
    end

    // Global control register, always updated immediately
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            en  <= 1'b1;
            inv <= 1'b0;
        end else if (wr_strobe_c && addr == CTRL_ADDR) begin
            en  <= wr_data_c[CTRL_EN_BIT];
            inv <= wr_data_c[CTRL_INV_BIT];
        end
    end

`ifdef SPI_PWM_SHADOW_EN
    logic [WIDTH-1:0] shadow [CHANNELS];

    // Writes land in shadows; all shadows go live as the counter wraps to 0
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < CHANNELS; c++) begin
                shadow[c] <= '0;
                level[c]  <= '0;
            end
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (wr_strobe_c && addr == ADDR_W'(c)) shadow[c] <= wr_data_c;
                if (wrap)
                    level[c] <= (wr_strobe_c && addr == ADDR_W'(c)) ? wr_data_c : shadow[c];
            end
        end
    end

    // Reads report the pending (shadow) value
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) rd_src[c] = shadow[c];
    end
`else
    // Level writes go straight to the active registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < CHANNELS; c++) level[c] <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++)
                if (wr_strobe_c && addr == ADDR_W'(c)) level[c] <= wr_data_c;
        end
    end

    // Reads report the active value
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) rd_src[c] = level[c];
    end
`endif

    // Read mux; unmapped addresses return zero
    always_comb begin
        rd_data = '0;
        if (rd_req_c) begin
            if (addr == CTRL_ADDR) rd_data = WIDTH'({inv, en});
            for (int c = 0; c < CHANNELS; c++)
                if (addr == ADDR_W'(c)) rd_data = rd_src[c];
        end
    end

    // Registered PWM compare
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pwm_out <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++)
                pwm_out[c] <= en & ((counter < level[c]) ^ inv);
        end
    end

endmodule

// File: tb/tb_spi_pwm_bank.sv
// Bench for spi_pwm_bank: an 8-bit/7-channel and a 12-bit/3-channel instance
// share sclk/mosi and are selected by their own chip selects.
module tb_spi_pwm_bank;

    localparam int CH0 = 7;
    localparam int W0  = 8;
    localparam int CH1 = 3;
    localparam int W1  = 12;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic sclk = 1'b0;
    logic mosi = 1'b0;
    logic cs_n0 = 1'b1;
    logic cs_n1 = 1'b1;
    logic miso0, miso1;
    logic [CH0-1:0] pwm0;
    logic [CH1-1:0] pwm1;
    int dsel = 0;

    always #5 clk = ~clk;

    spi_pwm_bank #(.CHANNELS(CH0), .WIDTH(W0)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .sclk(sclk), .cs_n(cs_n0),
        .mosi(mosi), .miso(miso0), .pwm_out(pwm0)
    );

    spi_pwm_bank #(.CHANNELS(CH1), .WIDTH(W1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .sclk(sclk), .cs_n(cs_n1),
        .mosi(mosi), .miso(miso1), .pwm_out(pwm1)
    );

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    typedef struct {
        int         ch;
        logic [7:0] ctrl;
        logic [7:0] lvl;
        int         high;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[8];
    int errors = 0;
    int checks = 0;

    task automatic expect_val(input string name, input logic [31:0] v);
        exp_t e;
        e.name = name;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    task automatic check(input logic [31:0] act);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty actual=0x%0h", act);
        end else begin
            e = exp_q.pop_front();
            if (act !== e.val) begin
                errors++;
                $display("FAIL %s actual=0x%0h required=0x%0h", e.name, act, e.val);
            end
        end
    endtask

    task automatic clkw(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic cur_miso();
        return (dsel != 0) ? miso1 : miso0;
    endfunction

    task automatic spi_bit(input logic b);
        mosi = b;
        clkw(4);
        sclk = 1'b1;
        clkw(4);
        sclk = 1'b0;
    endtask

    task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) begin
            mosi = tx[i];
            clkw(4);
            rx[i] = cur_miso();
            sclk = 1'b1;
            clkw(4);
            sclk = 1'b0;
        end
    endtask

    task automatic cs_lo();
        if (dsel != 0) cs_n1 = 1'b0;
        else           cs_n0 = 1'b0;
        clkw(4);
    endtask

    task automatic cs_hi();
        clkw(4);
        cs_n0 = 1'b1;
        cs_n1 = 1'b1;
        clkw(4);
    endtask

    task automatic spi_write(input logic [3:0] addr, input logic [23:0] data, input int nb);
        logic [7:0] rx;
        cs_lo();
        xfer({4'b1000, addr}, rx);
        for (int b = nb - 1; b >= 0; b--) xfer(data[b*8 +: 8], rx);
        cs_hi();
    endtask

    task automatic spi_read(input logic [3:0] addr, input int nb,
                            output logic [23:0] val, output logic [7:0] extra);
        logic [7:0] rx;
        cs_lo();
        xfer({4'b0000, addr}, rx);
        val = '0;
        for (int b = 0; b < nb; b++) begin
            xfer(8'h00, rx);
            val = {val[15:0], rx};
        end
        xfer(8'h00, extra);
        cs_hi();
    endtask

    task automatic measure(input int ch, input int n, output int cnt);
        logic b;
        cnt = 0;
        repeat (n) begin
            @(posedge clk);
            #1;
            b = (dsel != 0) ? pwm1[ch] : pwm0[ch];
            cnt += int'(b);
        end
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog expired actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        logic [23:0] val;
        logic [7:0]  extra;
        logic [7:0]  rx;
        int          cnt;

        vecs[0] = '{2, 8'h01, 8'h40, 64};
        vecs[1] = '{2, 8'h01, 8'hFF, 255};
        vecs[2] = '{2, 8'h01, 8'h00, 0};
        vecs[3] = '{0, 8'h01, 8'h80, 128};
        vecs[4] = '{6, 8'h01, 8'h01, 1};
        vecs[5] = '{3, 8'h01, 8'hFE, 254};
        vecs[6] = '{4, 8'h03, 8'h40, 191};
        vecs[7] = '{5, 8'h00, 8'h10, 0};

        // Reset state
        clkw(5);
        expect_val("reset_pwm", 32'h0);
        check(32'(pwm0));
        expect_val("reset_miso", 32'h0);
        check(32'(miso0));
        reset_n = 1'b1;
        clkw(5);

        dsel = 0;
        expect_val("reset_ctrl_rd", 32'h01);
        spi_read(4'hF, 1, val, extra);
        check(32'(val));
        expect_val("reset_lvl_rd", 32'h00);
        expect_val("read_tail_zero", 32'h00);
        spi_read(4'h0, 1, val, extra);
        check(32'(val));
        check(32'(extra));

        // Table: program ctrl+level, measure one full period, read back
        for (int i = 0; i < 8; i++) begin
            spi_write(4'hF, 24'(vecs[i].ctrl), 1);
            spi_write(4'(vecs[i].ch), 24'(vecs[i].lvl), 1);
            expect_val($sformatf("duty_v%0d", i), 32'(vecs[i].high));
            measure(vecs[i].ch, 255, cnt);
            check(32'(cnt));
            expect_val($sformatf("lvl_rd_v%0d", i), 32'(vecs[i].lvl));
            spi_read(4'(vecs[i].ch), 1, val, extra);
            check(32'(val));
        end

        // CTRL keeps only EN/INV; unmapped address reads zero and ignores writes
        spi_write(4'hF, 24'hFF, 1);
        expect_val("ctrl_mask_rd", 32'h03);
        spi_read(4'hF, 1, val, extra);
        check(32'(val));
        spi_write(4'h9, 24'h55, 1);
        expect_val("unmapped_rd", 32'h00);
        spi_read(4'h9, 1, val, extra);
        check(32'(val));
        spi_write(4'hF, 24'h01, 1);

        // Abort after 4 data bits leaves ch3 unchanged; following write lands
        cs_lo();
        xfer(8'h83, rx);
        for (int i = 0; i < 4; i++) spi_bit(1'b0);
        cs_hi();
        expect_val("abort_keep", 32'hFE);
        spi_read(4'h3, 1, val, extra);
        check(32'(val));
        spi_write(4'h3, 24'h11, 1);
        expect_val("post_abort_wr", 32'h11);
        spi_read(4'h3, 1, val, extra);
        check(32'(val));

        // Commit timing: ch1 0x00 -> 0xFF, output flips 4 clk after last rise
        cs_lo();
        xfer(8'h81, rx);
        for (int i = 0; i < 7; i++) spi_bit(1'b1);
        mosi = 1'b1;
        clkw(4);
        sclk = 1'b1;
        clkw(3);
`ifndef SPI_PWM_SHADOW_EN
        expect_val("commit_plus3", 32'h0);
        check(32'(pwm0[1]));
`endif
        clkw(1);
`ifndef SPI_PWM_SHADOW_EN
        expect_val("commit_plus4", 32'h1);
        check(32'(pwm0[1]));
`endif
        clkw(1);
        sclk = 1'b0;
        cs_hi();
        clkw(260);
        expect_val("commit_settled", 32'h1);
        check(32'(pwm0[1]));

        // Reset mid read frame: ch0 = 0x80 so miso carries a 1 first
        cs_lo();
        xfer(8'h00, rx);
        clkw(5);
        expect_val("rd_msb_before_reset", 32'h1);
        check(32'(miso0));
        reset_n = 1'b0;
        #1;
        expect_val("midframe_reset_pwm", 32'h0);
        check(32'(pwm0));
        expect_val("midframe_reset_miso", 32'h0);
        check(32'(miso0));
        cs_n0 = 1'b1;
        sclk  = 1'b0;
        clkw(3);
        reset_n = 1'b1;
        clkw(3);
        expect_val("post_reset_ctrl", 32'h01);
        spi_read(4'hF, 1, val, extra);
        check(32'(val));
        expect_val("post_reset_lvl0", 32'h00);
        spi_read(4'h0, 1, val, extra);
        check(32'(val));
        expect_val("post_reset_duty0", 32'h0);
        measure(0, 255, cnt);
        check(32'(cnt));

        // 12-bit instance: two data bytes, excess high bits dropped
        dsel = 1;
        spi_write(4'h0, 24'h00F800, 2);
        expect_val("w12_lvl_rd", 32'h0800);
        expect_val("w12_tail_zero", 32'h00);
        spi_read(4'h0, 2, val, extra);
        check(32'(val));
        check(32'(extra));
        expect_val("w12_duty", 32'd2048);
        measure(0, 4095, cnt);
        check(32'(cnt));
        expect_val("w12_unmapped", 32'h0000);
        spi_read(4'h5, 2, val, extra);
        check(32'(val));
        expect_val("w12_ctrl_rd", 32'h0001);
        spi_read(4'hF, 2, val, extra);
        check(32'(val));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
